// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the time-multiplexed S-box scheduler:
//   WORD_W / STATE_W    - SubWord and state widths
//   ARB_FIXED_KS/ARB_RR - arbitration mode encodings for ARB_MODE
//   state_e             - scheduler FSM states
//   sbox()              - AES forward S-box for one byte
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned STATE_W      = 128;
    localparam int unsigned ARB_FIXED_KS = 0;
    localparam int unsigned ARB_RR       = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KS_RUN = 2'd2
    } state_e;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box = affine(x^254). The square-and-multiply chain accumulates
    // x^2 * x^4 * ... * x^128 = x^254, which is the inverse (0 maps to 0).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/sbox_word.sv
// ---------------------------------------------------------------------------
// sbox_word
// SubWord unit: four byte-wise S-boxes, purely combinational.
//   word_i [31:0] - input word
//   word_o [31:0] - SubWord(word_i), byte lanes kept in place
// ---------------------------------------------------------------------------
module sbox_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign word_o[8*g +: 8] = sbox(word_i[8*g +: 8]);
    end

endmodule

// File: rtl/subbytes_scheduler.sv
// ---------------------------------------------------------------------------
// subbytes_scheduler
// Shares one SubWord unit between 128-bit SubBytes requests (one column per
// cycle, four cycles) and 32-bit key-expansion SubWord requests (one cycle).
//   ARB_MODE        - 0: key schedule wins ties, 1: round-robin on ties
//   clk, rst_n      - clock, asynchronous active-low reset
//   st_req_valid/st_req_ready, st_in[127:0]  - state request
//   st_rsp_valid, st_out[127:0]              - state result pulse / data
//   ks_req_valid/ks_req_ready, ks_in[31:0]   - key-expansion request
//   ks_rsp_valid, ks_out[31:0]               - key result pulse / data
//   busy            - FSM not in IDLE
// ---------------------------------------------------------------------------
module subbytes_scheduler
    import aes_pkg::*;
#(
    parameter int unsigned ARB_MODE = ARB_FIXED_KS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               st_req_valid,
    output logic               st_req_ready,
    input  logic [STATE_W-1:0] st_in,
    output logic               st_rsp_valid,
    output logic [STATE_W-1:0] st_out,
    input  logic               ks_req_valid,
    output logic               ks_req_ready,
    input  logic [WORD_W-1:0]  ks_in,
    output logic               ks_rsp_valid,
    output logic [WORD_W-1:0]  ks_out,
    output logic               busy
);

    state_e               state_q, state_d;
    logic [1:0]           col_q, col_d;
    logic                 last_ks_q, last_ks_d;   // 1: ks served last
    logic [STATE_W-1:0]   st_cap_q, st_cap_d;
    logic [WORD_W-1:0]    ks_cap_q, ks_cap_d;
    logic [95:0]          buf_q, buf_d;
    logic [STATE_W-1:0]   st_out_q, st_out_d;
    logic [WORD_W-1:0]    ks_out_q, ks_out_d;
    logic                 st_rsp_q, st_rsp_d;
    logic                 ks_rsp_q, ks_rsp_d;

    logic                 grant_st, grant_ks;
    logic                 st_acc, ks_acc;
    logic [WORD_W-1:0]    sb_in, sb_out;

    sbox_word u_sbox_word (
        .word_i (sb_in),
        .word_o (sb_out)
    );

    // Arbitration on the raw valids; only meaningful while IDLE.
    always_comb begin
        grant_st = 1'b0;
        grant_ks = 1'b0;
        if (st_req_valid && ks_req_valid) begin
            if (ARB_MODE == ARB_RR && last_ks_q) begin
                grant_st = 1'b1;
            end else begin
                grant_ks = 1'b1;
            end
        end else begin
            grant_st = st_req_valid;
            grant_ks = ks_req_valid;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        unique case (state_q)
            IDLE: begin
                if (ks_acc) begin
                    state_d = KS_RUN;
                end else if (st_acc) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                end
            end
            ST_RUN: begin
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            KS_RUN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Ready is gated by rst_n so both readies read 0 while reset is held.
    always_comb begin
        st_req_ready = rst_n && (state_q == IDLE) && grant_st;
        ks_req_ready = rst_n && (state_q == IDLE) && grant_ks;
        busy         = (state_q != IDLE);
        sb_in        = '0;
        unique case (state_q)
            KS_RUN: sb_in = ks_cap_q;
            ST_RUN: begin
                unique case (col_q)
                    2'd0:    sb_in = st_cap_q[127:96];
                    2'd1:    sb_in = st_cap_q[95:64];
                    2'd2:    sb_in = st_cap_q[63:32];
                    default: sb_in = st_cap_q[31:0];
                endcase
            end
            default: sb_in = '0;
        endcase
    end

    assign st_acc = st_req_valid && st_req_ready;
    assign ks_acc = ks_req_valid && ks_req_ready;

    // ---------------- Datapath ----------------
    always_comb begin
        st_cap_d  = st_cap_q;
        ks_cap_d  = ks_cap_q;
        buf_d     = buf_q;
        st_out_d  = st_out_q;
        ks_out_d  = ks_out_q;
        last_ks_d = last_ks_q;
        st_rsp_d  = 1'b0;
        ks_rsp_d  = 1'b0;

        if (st_acc) begin
            st_cap_d  = st_in;
            last_ks_d = 1'b0;
        end
        if (ks_acc) begin
            ks_cap_d  = ks_in;
            last_ks_d = 1'b1;
        end

        if (state_q == KS_RUN) begin
            ks_out_d = sb_out;
            ks_rsp_d = 1'b1;
        end

        if (state_q == ST_RUN) begin
            unique case (col_q)
                2'd0: buf_d[95:64] = sb_out;
                2'd1: buf_d[63:32] = sb_out;
                2'd2: buf_d[31:0]  = sb_out;
                default: begin
                    st_out_d = {buf_q, sb_out};
                    st_rsp_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_cap_q  <= '0;
            ks_cap_q  <= '0;
            buf_q     <= '0;
            st_out_q  <= '0;
            ks_out_q  <= '0;
            last_ks_q <= 1'b0;
            st_rsp_q  <= 1'b0;
            ks_rsp_q  <= 1'b0;
        end else begin
            st_cap_q  <= st_cap_d;
            ks_cap_q  <= ks_cap_d;
            buf_q     <= buf_d;
            st_out_q  <= st_out_d;
            ks_out_q  <= ks_out_d;
            last_ks_q <= last_ks_d;
            st_rsp_q  <= st_rsp_d;
            ks_rsp_q  <= ks_rsp_d;
        end
    end

    assign st_out       = st_out_q;
    assign ks_out       = ks_out_q;
    assign st_rsp_valid = st_rsp_q;
    assign ks_rsp_valid = ks_rsp_q;

endmodule

// File: tb/tb_subbytes_scheduler.sv
// ---------------------------------------------------------------------------
// tb_subbytes_scheduler
// dut0: ARB_MODE=0 (fixed key-schedule priority), scoreboard-checked.
// dut1: ARB_MODE=1 (round-robin), used for the alternating-tie scenario.
// ---------------------------------------------------------------------------
module tb_subbytes_scheduler;

    localparam logic [127:0] ST_VEC = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] ST_RES = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         st_v0 = 0, st_rdy0, st_rv0, ks_v0 = 0, ks_rdy0, ks_rv0, busy0;
    logic [127:0] st_in0 = '0, st_out0;
    logic [31:0]  ks_in0 = '0, ks_out0;
    logic         st_v1 = 0, st_rdy1, st_rv1, ks_v1 = 0, ks_rdy1, ks_rv1, busy1;
    logic [127:0] st_in1 = '0, st_out1;
    logic [31:0]  ks_in1 = '0, ks_out1;

    subbytes_scheduler #(.ARB_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .st_req_valid(st_v0), .st_req_ready(st_rdy0), .st_in(st_in0),
        .st_rsp_valid(st_rv0), .st_out(st_out0),
        .ks_req_valid(ks_v0), .ks_req_ready(ks_rdy0), .ks_in(ks_in0),
        .ks_rsp_valid(ks_rv0), .ks_out(ks_out0), .busy(busy0)
    );

    subbytes_scheduler #(.ARB_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .st_req_valid(st_v1), .st_req_ready(st_rdy1), .st_in(st_in1),
        .st_rsp_valid(st_rv1), .st_out(st_out1),
        .ks_req_valid(ks_v1), .ks_req_ready(ks_rdy1), .ks_in(ks_in1),
        .ks_rsp_valid(ks_rv1), .ks_out(ks_out1), .busy(busy1)
    );

    int checks = 0;
    int failures = 0;

    logic [127:0] st_exp_q[$];
    logic [31:0]  ks_exp_q[$];
    int           ord_q[$];      // 0 = ks response, 1 = st response
    logic [127:0] st_prev = '0, st_e;
    logic [31:0]  ks_prev = '0, ks_e;

    // Scoreboard for dut0: pop on every response pulse, otherwise outputs must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            st_prev = st_out0;
            ks_prev = ks_out0;
        end else begin
            checks++;
            if (st_rv0) begin
                ord_q.push_back(1);
                if (st_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL st_unexpected_rsp got=%h required=none", st_out0);
                end else begin
                    st_e = st_exp_q.pop_front();
                    if (st_out0 !== st_e) begin
                        failures++;
                        $display("FAIL st_out got=%h required=%h", st_out0, st_e);
                    end
                end
            end else if (st_out0 !== st_prev) begin
                failures++;
                $display("FAIL st_out_hold got=%h required=%h", st_out0, st_prev);
            end
            checks++;
            if (ks_rv0) begin
                ord_q.push_back(0);
                if (ks_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ks_unexpected_rsp got=%h required=none", ks_out0);
                end else begin
                    ks_e = ks_exp_q.pop_front();
                    if (ks_out0 !== ks_e) begin
                        failures++;
                        $display("FAIL ks_out got=%h required=%h", ks_out0, ks_e);
                    end
                end
            end else if (ks_out0 !== ks_prev) begin
                failures++;
                $display("FAIL ks_out_hold got=%h required=%h", ks_out0, ks_prev);
            end
            st_prev = st_out0;
            ks_prev = ks_out0;
        end
    end

    // Drivers (called just after a negedge); lat = cycles from accept to pulse, -1 on timeout.
    task automatic send_st0(input logic [127:0] d, input logic [127:0] e,
                            input bit scramble, output int lat);
        int g = 0;
        st_v0 = 1'b1; st_in0 = d;
        #1;
        while (!st_rdy0 && g < 40) begin @(negedge clk); #1; g++; end
        if (!st_rdy0) begin st_v0 = 1'b0; lat = -1; return; end
        st_exp_q.push_back(e);
        @(negedge clk);
        st_v0 = 1'b0;
        lat = 1;
        while (!st_rv0 && lat < 20) begin
            if (scramble) st_in0 = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send_ks0(input logic [31:0] d, input logic [31:0] e, output int lat);
        int g = 0;
        ks_v0 = 1'b1; ks_in0 = d;
        #1;
        while (!ks_rdy0 && g < 40) begin @(negedge clk); #1; g++; end
        if (!ks_rdy0) begin ks_v0 = 1'b0; lat = -1; return; end
        ks_exp_q.push_back(e);
        @(negedge clk);
        ks_v0 = 1'b0;
        ks_in0 = $urandom;
        lat = 1;
        while (!ks_rv0 && lat < 20) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        st_v0 = 1; ks_v0 = 1; st_v1 = 1; ks_v1 = 1;
        st_in0 = ST_VEC; ks_in0 = 32'hcf4f3c09; st_in1 = ST_VEC; ks_in1 = 32'hcf4f3c09;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({st_rdy0, ks_rdy0, st_rv0, ks_rv0, busy0} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl0 got=%b required=00000", {st_rdy0, ks_rdy0, st_rv0, ks_rv0, busy0});
        end
        checks++;
        if (st_out0 !== '0 || ks_out0 !== '0) begin
            failures++;
            $display("FAIL reset_data0 got=%h/%h required=0/0", st_out0, ks_out0);
        end
        checks++;
        if ({st_rdy1, ks_rdy1, st_rv1, ks_rv1, busy1} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl1 got=%b required=00000", {st_rdy1, ks_rdy1, st_rv1, ks_rv1, busy1});
        end
        checks++;
        if (st_out1 !== '0 || ks_out1 !== '0) begin
            failures++;
            $display("FAIL reset_data1 got=%h/%h required=0/0", st_out1, ks_out1);
        end
        st_v0 = 0; ks_v0 = 0; st_v1 = 0; ks_v1 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_st_single();
        int lat;
        send_st0(ST_VEC, ST_RES, 1'b1, lat);
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL st_latency got=%0d required=5", lat);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL st_busy_at_rsp got=%b required=0", busy0);
        end
        @(negedge clk);
    endtask

    task automatic test_ks_single();
        int lat;
        send_ks0(32'hcf4f3c09, 32'h8a84eb01, lat);
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL ks_latency got=%0d required=2", lat);
        end
        @(negedge clk);
        send_ks0(32'h00000000, 32'h63636363, lat);
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL ks_latency_zero got=%0d required=2", lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        ks_v0 = 1'b1; ks_in0 = 32'h00000000;
        #1;
        while (!ks_rdy0 && n < 20) begin @(negedge clk); #1; n++; end
        ks_exp_q.push_back(32'h63636363);
        @(negedge clk);
        ks_in0 = 32'hffffffff;
        n = 1;
        #1;
        while (!ks_rdy0 && n < 10) begin @(negedge clk); #1; n++; end
        checks++;
        if (n != 2 || ks_rv0 !== 1'b1) begin
            failures++;
            $display("FAIL ks_back_to_back gap=%0d rsp=%b required gap=2 rsp=1", n, ks_rv0);
        end
        ks_exp_q.push_back(32'h16161616);
        @(negedge clk);
        ks_v0 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tie_fixed();
        int n;
        ord_q.delete();
        st_v0 = 1; st_in0 = ST_VEC; ks_v0 = 1; ks_in0 = 32'hcf4f3c09;
        #1;
        checks++;
        if ({ks_rdy0, st_rdy0} !== 2'b10) begin
            failures++;
            $display("FAIL tie_fixed_grant got=%b required=10", {ks_rdy0, st_rdy0});
        end
        ks_exp_q.push_back(32'h8a84eb01);
        @(negedge clk);
        ks_v0 = 1'b0; ks_in0 = $urandom;
        n = 1;
        #1;
        while (!st_rdy0 && n < 10) begin @(negedge clk); #1; n++; end
        checks++;
        if (n != 2 || ks_rv0 !== 1'b1) begin
            failures++;
            $display("FAIL tie_st_accept gap=%0d ks_rsp=%b required gap=2 ks_rsp=1", n, ks_rv0);
        end
        st_exp_q.push_back(ST_RES);
        @(negedge clk);
        st_v0 = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (ord_q.size() != 2 || ord_q[0] != 0 || ord_q[1] != 1) begin
            failures++;
            $display("FAIL tie_order got_size=%0d required=ks,st", ord_q.size());
        end
    endtask

    task automatic test_rr();
        logic [1:0] exp_g;
        int n;
        for (int i = 0; i < 3; i++) begin
            exp_g = (i == 1) ? 2'b01 : 2'b10;
            st_v1 = 1; st_in1 = ST_VEC; ks_v1 = 1; ks_in1 = 32'hffffffff;
            #1;
            checks++;
            if ({ks_rdy1, st_rdy1} !== exp_g) begin
                failures++;
                $display("FAIL rr_grant_%0d got=%b required=%b", i, {ks_rdy1, st_rdy1}, exp_g);
            end
            @(negedge clk);
            st_v1 = 0; ks_v1 = 0;
            n = 0;
            while (!(st_rv1 || ks_rv1) && n < 10) begin @(negedge clk); n++; end
            checks++;
            if (exp_g == 2'b10) begin
                if (ks_rv1 !== 1'b1 || ks_out1 !== 32'h16161616) begin
                    failures++;
                    $display("FAIL rr_rsp_%0d got ks_rsp=%b ks_out=%h required 1/16161616", i, ks_rv1, ks_out1);
                end
            end else begin
                if (st_rv1 !== 1'b1 || st_out1 !== ST_RES) begin
                    failures++;
                    $display("FAIL rr_rsp_%0d got st_rsp=%b st_out=%h required 1/%h", i, st_rv1, st_out1, ST_RES);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_collision();
        int n = 0;
        ord_q.delete();
        st_v0 = 1; st_in0 = ST_VEC;
        #1;
        while (!st_rdy0 && n < 20) begin @(negedge clk); #1; n++; end
        st_exp_q.push_back(ST_RES);
        @(negedge clk);
        st_v0 = 0;
        @(negedge clk);
        ks_v0 = 1; ks_in0 = 32'hffffffff;
        n = 2;
        #1;
        while (!ks_rdy0 && n < 12) begin @(negedge clk); #1; n++; end
        checks++;
        if (n != 5 || st_rv0 !== 1'b1) begin
            failures++;
            $display("FAIL collision_ks_accept cycle=%0d st_rsp=%b required cycle=5 st_rsp=1", n, st_rv0);
        end
        ks_exp_q.push_back(32'h16161616);
        @(negedge clk);
        ks_v0 = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (ord_q.size() != 2 || ord_q[0] != 1 || ord_q[1] != 0) begin
            failures++;
            $display("FAIL collision_order got_size=%0d required=st,ks", ord_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit seen = 0;
        int lat;
        st_v0 = 1; st_in0 = ST_VEC;
        #1;
        while (!st_rdy0 && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        st_v0 = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({st_rdy0, ks_rdy0, st_rv0, ks_rv0, busy0} !== 5'b0 || st_out0 !== '0 || ks_out0 !== '0) begin
            failures++;
            $display("FAIL reset_mid got ctrl=%b st_out=%h ks_out=%h required all 0",
                     {st_rdy0, ks_rdy0, st_rv0, ks_rv0, busy0}, st_out0, ks_out0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (st_rv0) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_mid_no_rsp got=1 required=0");
        end
        send_st0(ST_VEC, ST_RES, 1'b1, lat);
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL reset_mid_fresh_latency got=%0d required=5", lat);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_st_single();
        test_ks_single();
        test_back_to_back();
        test_tie_fixed();
        test_rr();
        test_collision();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (st_exp_q.size() != 0 || ks_exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_rsp got st=%0d ks=%0d required=0/0", st_exp_q.size(), ks_exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/subbytes_scheduler.md
# subbytes_scheduler

Time-multiplexed S-box controller that shares one 32-bit SubWord unit (four Sbox instances) between the round datapath and the key-expansion logic. A 128-bit SubBytes request is processed one column per cycle over four cycles; a 32-bit SubWord request from key expansion takes one cycle. The block replaces sixteen parallel Sbox instances in area-constrained builds and sits between the round controller and the encryption datapath.

## Interface
- ARB_MODE, default 0, arbitration on simultaneous requests: 0 = key-schedule fixed priority, 1 = round-robin.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_req_valid  in  1  state SubBytes request.
- st_req_ready  out  1  state request accepted this cycle.
- st_in  in  128  state as {w0,w1,w2,w3}, w0 = [127:96]; each word is one column, MSB byte first.
- st_rsp_valid  out  1  one-cycle pulse: st_out holds a new result.
- st_out  out  128  SubBytes(st_in), same word/byte layout.
- ks_req_valid  in  1  key-expansion SubWord request.
- ks_req_ready  out  1  key request accepted this cycle.
- ks_in  in  32  word to substitute (already RotWord'ed by the caller).
- ks_rsp_valid  out  1  one-cycle pulse: ks_out holds a new result.
- ks_out  out  32  SubWord(ks_in).
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ST_RUN, KS_RUN.
- IDLE: grant is computed combinationally from the valids; ready = (state==IDLE) && grant. A requester must not derive valid from ready.
- Grant with one requester: that requester. With both, ARB_MODE=0 grants ks. ARB_MODE=1 grants the requester not served last; the pointer resets to "st served last", so the first tie goes to ks.
- Accept (valid && ready) captures the input into an internal register. The requester may change inputs afterwards.
- KS accept: IDLE→KS_RUN. In KS_RUN the Sbox word input is the captured ks word. At the end of the cycle ks_out is loaded and ks_rsp_valid is set. The FSM then returns to IDLE.
- ST accept: IDLE→ST_RUN with col=0. In ST_RUN, col 0..3 drives w0..w3 in turn; each result goes into a 96-bit working buffer (cols 0-2). At col 3, st_out is loaded with {buf, result} and st_rsp_valid is set. The FSM then returns to IDLE.
- Non-preemptive. A request arriving during a job waits (ready low) until IDLE.
- Responses have no backpressure. The consumer must take the pulse.
- ks_out and st_out update atomically on their completion edge only, and hold their value otherwise.
- Reset, asynchronous at any time: state IDLE, col 0, RR pointer = st, all outputs 0 (st_out, ks_out, both rsp_valid, both ready, busy). An in-flight job is dropped and no response is issued.

## Timing
- KS: accept edge T → ks_rsp_valid high in cycle T+2. Back-to-back acceptance is possible at T+2, giving 1 job per 2 cycles.
- ST: accept edge T → st_rsp_valid high in cycle T+5. The next accept is possible in cycle T+5, giving 1 job per 5 cycles.
- A rsp_valid pulse and the next accept may coincide in the same IDLE cycle.
- busy is high from the cycle after an accept until the completion edge.
- The Sbox path is combinational within one cycle, with registered output. There is no multicycle path.

## Structure
- Shared package aes_pkg holds: WORD_W=32, STATE_W=128, the FSM state enum (IDLE/ST_RUN/KS_RUN), and ARB_FIXED_KS=0 / ARB_RR=1.
- One sub-module, sbox_word: four existing Sbox instances mapping 32→32 bits, byte-wise. This is the only Sbox logic in the block.
- The 2-bit col counter, the working buffer and the RR pointer live in the top level.

## Test plan
- ST single: st_in=193de3bea0f4e22b9ac68d2ae9f84808 → st_out=d42711aee0bf98f1b8b45de51e415230, st_rsp_valid exactly 5 cycles after accept.
- KS single: ks_in=cf4f3c09 → ks_out=8a84eb01, ks_rsp_valid 2 cycles after accept. Also check ks_in=00000000 → 63636363.
- Tie, ARB_MODE=0: both valid in IDLE → ks granted; st accepted at the ks completion cycle; order of responses ks then st. With ARB_MODE=1, repeated ties alternate ks, st, ks.
- Collision: ks_req_valid raised during ST_RUN col 1 → ks_req_ready stays low until IDLE. st_out is correct and ks follows; ks_out=16161616 for ks_in=ffffffff.
- Reset mid-job: rst_n low during ST_RUN col 2 → all outputs 0 immediately, no st_rsp_valid. After release, a fresh request completes normally.
- Hold/stability: change st_in every cycle after accept → result matches the captured value. st_out and ks_out are unchanged between completions.
